// File: rtl/mma_seq_pkg.sv
// Shared types for the K-tile GEMM sequencer: FSM states, accumulator load selects and defaults.
package mma_seq_pkg;

    localparam int KCNT_W_DEF = 8;
    localparam int P_DEF      = 8;

    typedef logic [4*P_DEF-1:0] acc_elem_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        OUT   = 3'd4
    } seq_state_e;

    typedef enum logic [1:0] {
        ACC_HOLD = 2'd0,
        ACC_ZERO = 2'd1,
        ACC_BIAS = 2'd2,
        ACC_D    = 2'd3
    } acc_sel_e;

endpackage

// File: rtl/mma_seq_acc_reg.sv
// M x N accumulator register; loads zero, a bias matrix or the MAC result, otherwise holds.
module mma_seq_acc_reg
    import mma_seq_pkg::*;
#(
    parameter int M     = 2,
    parameter int N     = 2,
    parameter int ACC_W = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  acc_sel_e                       sel_i,
    input  logic [M-1:0][N-1:0][ACC_W-1:0] bias_i,
    input  logic [M-1:0][N-1:0][ACC_W-1:0] d_i,
    output logic [M-1:0][N-1:0][ACC_W-1:0] acc_o
);

    logic [M-1:0][N-1:0][ACC_W-1:0] r_acc;

    // accumulator storage with synchronous active-high reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_acc <= '0;
        end else begin
            case (sel_i)
                ACC_ZERO: r_acc <= '0;
                ACC_BIAS: r_acc <= bias_i;
                ACC_D:    r_acc <= d_i;
                default:  r_acc <= r_acc;
            endcase
        end
    end

    assign acc_o = r_acc;

endmodule

// File: rtl/mma_ktile_sequencer.sv
// K-dimension reduction sequencer: fetch tile, issue to MAC, feed D back as C, emit final accumulator.
// Optional feature macro: MMA_SEQ_BIAS_EN (adds cmd_bias_i, used as the initial accumulator).
module mma_ktile_sequencer
    import mma_seq_pkg::*;
#(
    parameter int M      = 2,
    parameter int N      = 2,
    parameter int K      = 2,
    parameter int P      = 8,
    parameter int KCNT_W = KCNT_W_DEF
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           cmd_valid_i,
    output logic                           cmd_ready_o,
    input  logic [KCNT_W-1:0]              cmd_ktiles_i,
    input  logic                           cmd_halved_i,
`ifdef MMA_SEQ_BIAS_EN
    input  logic [M-1:0][N-1:0][4*P-1:0]   cmd_bias_i,
`endif
    input  logic                           tile_valid_i,
    output logic                           tile_ready_o,
    input  logic [M-1:0][K-1:0][P-1:0]     tile_a_i,
    input  logic [K-1:0][N-1:0][P-1:0]     tile_b_i,
    output logic                           mma_valid_o,
    input  logic                           mma_ready_i,
    output logic [M-1:0][K-1:0][P-1:0]     mma_a_o,
    output logic [K-1:0][N-1:0][P-1:0]     mma_b_o,
    output logic [M-1:0][N-1:0][4*P-1:0]   mma_c_o,
    output logic                           mma_halved_o,
    input  logic                           mma_valid_i,
    output logic                           mma_ready_o,
    input  logic [M-1:0][N-1:0][4*P-1:0]   mma_d_i,
    output logic                           res_valid_o,
    input  logic                           res_ready_i,
    output logic [M-1:0][N-1:0][4*P-1:0]   res_d_o,
    output logic                           busy_o
);

    seq_state_e                     r_state;
    seq_state_e                     w_next;
    logic [KCNT_W-1:0]              r_cnt;
    logic [KCNT_W-1:0]              r_ktiles;
    logic [KCNT_W-1:0]              w_cnt_nxt;
    logic                           r_halved;
    logic [M-1:0][K-1:0][P-1:0]     r_a;
    logic [K-1:0][N-1:0][P-1:0]     r_b;
    logic [M-1:0][N-1:0][4*P-1:0]   w_acc;
    logic [M-1:0][N-1:0][4*P-1:0]   w_bias;
    acc_sel_e                       w_acc_sel;
    logic                           w_cmd_fire;
    logic                           w_tile_fire;
    logic                           w_d_fire;

`ifdef MMA_SEQ_BIAS_EN
    assign w_bias = cmd_bias_i;
`else
    assign w_bias = '0;
`endif

    assign w_cmd_fire  = (r_state == IDLE)  && cmd_valid_i;
    assign w_tile_fire = (r_state == FETCH) && tile_valid_i;
    // results drained in IDLE are discarded; only WAIT loads the accumulator
    assign w_d_fire    = (r_state == WAIT)  && mma_valid_i;
    assign w_cnt_nxt   = r_cnt + {{(KCNT_W-1){1'b0}}, 1'b1};

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (cmd_valid_i) begin
                    w_next = (cmd_ktiles_i == '0) ? OUT : FETCH;
                end else begin
                    w_next = IDLE;
                end
            end
            FETCH:   w_next = tile_valid_i ? ISSUE : FETCH;
            ISSUE:   w_next = mma_ready_i ? WAIT : ISSUE;
            WAIT: begin
                if (mma_valid_i) begin
                    w_next = (w_cnt_nxt == r_ktiles) ? OUT : FETCH;
                end else begin
                    w_next = WAIT;
                end
            end
            OUT:     w_next = res_ready_i ? IDLE : OUT;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs decoded from the state register
    always_comb begin
        cmd_ready_o  = 1'b0;
        tile_ready_o = 1'b0;
        mma_valid_o  = 1'b0;
        mma_ready_o  = 1'b0;
        res_valid_o  = 1'b0;
        busy_o       = 1'b1;
        case (r_state)
            IDLE: begin
                cmd_ready_o = 1'b1;
                mma_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            FETCH:   tile_ready_o = 1'b1;
            ISSUE:   mma_valid_o  = 1'b1;
            WAIT:    mma_ready_o  = 1'b1;
            OUT:     res_valid_o  = 1'b1;
            default: busy_o       = 1'b1;
        endcase
    end

    // accumulator load select
    always_comb begin
        w_acc_sel = ACC_HOLD;
        if (w_cmd_fire) begin
`ifdef MMA_SEQ_BIAS_EN
            w_acc_sel = ACC_BIAS;
`else
            w_acc_sel = ACC_ZERO;
`endif
        end else if (w_d_fire) begin
            w_acc_sel = ACC_D;
        end else begin
            w_acc_sel = ACC_HOLD;
        end
    end

    // command latches, tile counter and operand registers
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            r_cnt    <= '0;
            r_ktiles <= '0;
            r_halved <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_cnt    <= '0;
                r_ktiles <= cmd_ktiles_i;
                r_halved <= cmd_halved_i;
            end else if (w_d_fire) begin
                r_cnt    <= w_cnt_nxt;
            end
            if (w_tile_fire) begin
                r_a <= tile_a_i;
                r_b <= tile_b_i;
            end
        end
    end

    mma_seq_acc_reg #(
        .M     (M),
        .N     (N),
        .ACC_W (4*P)
    ) u_acc (
        .clk_i  (clk_i),
        .rst_i  (rst_ni),
        .sel_i  (w_acc_sel),
        .bias_i (w_bias),
        .d_i    (mma_d_i),
        .acc_o  (w_acc)
    );

    assign mma_a_o      = r_a;
    assign mma_b_o      = r_b;
    assign mma_c_o      = w_acc;
    assign res_d_o      = w_acc;
    assign mma_halved_o = r_halved;

endmodule

// File: tb/tb_mma_ktile_sequencer.sv
// Directed, table-driven bench for mma_ktile_sequencer with a behavioural MAC responder (M=N=K=2, P=8).
module tb_mma_ktile_sequencer;

    typedef struct packed {
        logic [7:0]       ktiles;
        logic             halved;
        logic [3:0][7:0]  a;
        logic [3:0][7:0]  b;
        logic [3:0][31:0] exp;
    } vec_t;

    logic             clk;
    logic             rst_ni;
    logic             cmd_valid_i;
    logic             cmd_ready_o;
    logic [7:0]       cmd_ktiles_i;
    logic             cmd_halved_i;
    logic [3:0][31:0] cmd_bias_i;
    logic             tile_valid_i;
    logic             tile_ready_o;
    logic [3:0][7:0]  tile_a_i;
    logic [3:0][7:0]  tile_b_i;
    logic             mma_valid_o;
    logic             mma_ready_i;
    logic [3:0][7:0]  mma_a_o;
    logic [3:0][7:0]  mma_b_o;
    logic [3:0][31:0] mma_c_o;
    logic             mma_halved_o;
    logic             mma_valid_i;
    logic             mma_ready_o;
    logic [3:0][31:0] mma_d_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic [3:0][31:0] res_d_o;
    logic             busy_o;

    int n_chk;
    int n_err;
    vec_t vecs [5];

    mma_ktile_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_ni),
        .cmd_valid_i  (cmd_valid_i),
        .cmd_ready_o  (cmd_ready_o),
        .cmd_ktiles_i (cmd_ktiles_i),
        .cmd_halved_i (cmd_halved_i),
`ifdef MMA_SEQ_BIAS_EN
        .cmd_bias_i   (cmd_bias_i),
`endif
        .tile_valid_i (tile_valid_i),
        .tile_ready_o (tile_ready_o),
        .tile_a_i     (tile_a_i),
        .tile_b_i     (tile_b_i),
        .mma_valid_o  (mma_valid_o),
        .mma_ready_i  (mma_ready_i),
        .mma_a_o      (mma_a_o),
        .mma_b_o      (mma_b_o),
        .mma_c_o      (mma_c_o),
        .mma_halved_o (mma_halved_o),
        .mma_valid_i  (mma_valid_i),
        .mma_ready_o  (mma_ready_o),
        .mma_d_i      (mma_d_i),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .res_d_o      (res_d_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // row-major element order: (0,0),(0,1),(1,0),(1,1)
    function automatic logic [3:0][7:0] pk8(input int x0, input int x1, input int x2, input int x3);
        pk8 = {8'(x3), 8'(x2), 8'(x1), 8'(x0)};
    endfunction

    function automatic logic [3:0][31:0] pk32(input int x0, input int x1, input int x2, input int x3);
        pk32 = {32'(x3), 32'(x2), 32'(x1), 32'(x0)};
    endfunction

    // reference MAC: D = A*B + C, signed operands, wrapping 32-bit accumulators
    function automatic logic [3:0][31:0] mac(input logic [3:0][7:0] a, input logic [3:0][7:0] b,
                                             input logic [3:0][31:0] c);
        logic [3:0][31:0] d;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                int s;
                s = $signed(c[i*2+j]);
                for (int k = 0; k < 2; k++) begin
                    int ai;
                    int bi;
                    ai = $signed(a[i*2+k]);
                    bi = $signed(b[k*2+j]);
                    s = s + ai * bi;
                end
                d[i*2+j] = 32'(s);
            end
        end
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic [3:0][31:0] acc_m;
        acc_m        = cmd_bias_i;
        cmd_ktiles_i = v.ktiles;
        cmd_halved_i = v.halved;
        cmd_valid_i  = 1'b1;
        chk("cmd_ready_idle", 128'(cmd_ready_o), 128'd1);
        tick();
        cmd_valid_i = 1'b0;
        for (int t = 0; t < int'(v.ktiles); t++) begin
            chk("tile_ready_fetch", 128'(tile_ready_o), 128'd1);
            chk("mma_valid_fetch", 128'(mma_valid_o), 128'd0);
            tile_a_i     = v.a;
            tile_b_i     = v.b;
            tile_valid_i = 1'b1;
            tick();
            tile_valid_i = 1'b0;
            tile_a_i     = 32'($urandom);
            tile_b_i     = 32'($urandom);
            chk("mma_valid_issue", 128'(mma_valid_o), 128'd1);
            chk("mma_c_issue", 128'(mma_c_o), 128'(acc_m));
            chk("mma_a_issue", 128'(mma_a_o), 128'(v.a));
            chk("mma_b_issue", 128'(mma_b_o), 128'(v.b));
            chk("mma_halved", 128'(mma_halved_o), 128'(v.halved));
            mma_ready_i = 1'b0;
            tick();
            chk("mma_valid_hold", 128'(mma_valid_o), 128'd1);
            chk("mma_c_hold", 128'(mma_c_o), 128'(acc_m));
            mma_ready_i = 1'b1;
            tick();
            mma_ready_i = 1'b0;
            chk("mma_valid_wait", 128'(mma_valid_o), 128'd0);
            chk("mma_ready_wait", 128'(mma_ready_o), 128'd1);
            tick();
            acc_m       = mac(v.a, v.b, acc_m);
            mma_d_i     = acc_m;
            mma_valid_i = 1'b1;
            tick();
            mma_valid_i = 1'b0;
            mma_d_i     = '1;
        end
        chk("res_valid_out", 128'(res_valid_o), 128'd1);
        chk("res_d_out", 128'(res_d_o), 128'(v.exp));
        chk("busy_out", 128'(busy_o), 128'd1);
        chk("tile_ready_out", 128'(tile_ready_o), 128'd0);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("res_valid_done", 128'(res_valid_o), 128'd0);
        chk("cmd_ready_done", 128'(cmd_ready_o), 128'd1);
    endtask

    initial begin
        vec_t vb;
        n_chk        = 0;
        n_err        = 0;
        rst_ni       = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_ktiles_i = 8'd0;
        cmd_halved_i = 1'b0;
        cmd_bias_i   = '0;
        tile_valid_i = 1'b0;
        tile_a_i     = '0;
        tile_b_i     = '0;
        mma_ready_i  = 1'b0;
        mma_valid_i  = 1'b0;
        mma_d_i      = '0;
        res_ready_i  = 1'b0;

        vecs[0] = '{8'd1, 1'b0, pk8(1, 2, 3, 4),       pk8(5, 6, 7, 8),           pk32(19, 22, 43, 50)};
        vecs[1] = '{8'd3, 1'b1, pk8(1, 2, 3, 4),       pk8(5, 6, 7, 8),           pk32(57, 66, 129, 150)};
        vecs[2] = '{8'd2, 1'b0, pk8(-1, 0, 0, -1),     pk8(3, -4, 5, 6),          pk32(-6, 8, -10, -12)};
        vecs[3] = '{8'd1, 1'b1, pk8(127, 127, 127, 127), pk8(-128, -128, -128, -128),
                    pk32(-32512, -32512, -32512, -32512)};
        vecs[4] = '{8'd2, 1'b0, pk8(2, 0, 0, 3),       pk8(1, 1, -1, 2),          pk32(4, 4, -6, 12)};

        tick();
        tick();
        chk("rst_cmd_ready", 128'(cmd_ready_o), 128'd1);
        chk("rst_busy", 128'(busy_o), 128'd0);
        chk("rst_valids", 128'({tile_ready_o, mma_valid_o, res_valid_o}), 128'd0);
        chk("rst_acc", 128'(mma_c_o), 128'd0);
        chk("rst_halved", 128'(mma_halved_o), 128'd0);
        rst_ni = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i]);
        end

        // ktiles=0 straight to OUT, then hold result with res_ready low and a stray command present
        cmd_ktiles_i = 8'd0;
        cmd_valid_i  = 1'b1;
        tick();
        cmd_ktiles_i = 8'd7;
        chk("k0_res_valid", 128'(res_valid_o), 128'd1);
        chk("k0_res_zero", 128'(res_d_o), 128'd0);
        chk("k0_no_tile", 128'({tile_ready_o, mma_valid_o}), 128'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("hold_res_valid", 128'(res_valid_o), 128'd1);
            chk("hold_res_d", 128'(res_d_o), 128'd0);
            chk("hold_cmd_ready", 128'(cmd_ready_o), 128'd0);
            chk("hold_busy", 128'(busy_o), 128'd1);
        end
        cmd_valid_i = 1'b0;
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        chk("hold_release_idle", 128'(cmd_ready_o), 128'd1);

        // reset pulsed while waiting for the MAC, then a late result is drained
        cmd_ktiles_i = 8'd2;
        cmd_halved_i = 1'b1;
        cmd_valid_i  = 1'b1;
        tick();
        cmd_valid_i  = 1'b0;
        tile_a_i     = vecs[0].a;
        tile_b_i     = vecs[0].b;
        tile_valid_i = 1'b1;
        tick();
        tile_valid_i = 1'b0;
        mma_ready_i  = 1'b1;
        tick();
        mma_ready_i  = 1'b0;
        chk("pre_rst_wait", 128'(mma_ready_o & busy_o), 128'd1);
        rst_ni = 1'b1;
        tick();
        rst_ni = 1'b0;
        chk("midrst_valids", 128'({tile_ready_o, mma_valid_o, res_valid_o}), 128'd0);
        chk("midrst_cmd_ready", 128'(cmd_ready_o), 128'd1);
        chk("midrst_busy", 128'(busy_o), 128'd0);
        chk("midrst_a_clr", 128'(mma_a_o), 128'd0);
        chk("midrst_halved", 128'(mma_halved_o), 128'd0);
        chk("midrst_drain_ready", 128'(mma_ready_o), 128'd1);
        mma_d_i     = pk32(9, 9, 9, 9);
        mma_valid_i = 1'b1;
        tick();
        mma_valid_i = 1'b0;
        chk("drain_acc_zero", 128'(mma_c_o), 128'd0);
        chk("drain_idle", 128'({cmd_ready_o, busy_o, res_valid_o}), 128'b100);

        run_vec(vecs[0]);

`ifdef MMA_SEQ_BIAS_EN
        cmd_bias_i = pk32(100, 100, 100, 100);
        vb         = vecs[0];
        vb.exp     = pk32(119, 122, 143, 150);
        run_vec(vb);
        cmd_bias_i = '0;
`else
        vb = vecs[1];
        run_vec(vb);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
